pipe_sched: RTL and testbench

- Round-robin scheduler that shares one 3-stage arithmetic pipeline, F=(A+B)+(C-D) then times D, mod 2^N, among NREQ requesters.
- Issues at most one operation per cycle into the datapath and carries a requester-ID tag alongside it in a valid/tag shift register.
- Captures pipe_f into a result FIFO and returns results with their ID over a valid/ready response port.
- Credit-limits issue so the non-stallable pipeline can never overflow the FIFO.

---
 rtl/pipe_sched.sv | 168 ++++++++++++++++
 tb/tb_pipe_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency arithmetic pipeline among
// NREQ requesters; results return in issue order through a credit-limited FIFO.
module pipe_sched #(
  parameter int unsigned N      = 100,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned LAT    = 3,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  input  logic [NREQ*N-1:0]   req_c,
  input  logic [NREQ*N-1:0]   req_d,
  output logic [N-1:0]        pipe_a,
  output logic [N-1:0]        pipe_b,
  output logic [N-1:0]        pipe_c,
  output logic [N-1:0]        pipe_d,
  input  logic [N-1:0]        pipe_f,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [N-1:0]        rsp_data,
  output logic                busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [IDW-1:0] ptr;
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [LAT+1];
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [IDW-1:0] mem_id   [DEPTH];
  logic [N-1:0]   mem_data [DEPTH];

  logic [N-1:0]   a_arr [NREQ];
  logic [N-1:0]   b_arr [NREQ];
  logic [N-1:0]   c_arr [NREQ];
  logic [N-1:0]   d_arr [NREQ];

  logic           credit_ok;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic           push;
  logic           pop;

  // Unpack the flat operand buses into per-requester arrays
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*N +: N];
    assign b_arr[g] = req_b[g*N +: N];
    assign c_arr[g] = req_c[g*N +: N];
    assign d_arr[g] = req_d[g*N +: N];
  end

  // Credit uses start-of-cycle occupancy; a same-cycle pop frees nothing yet
  assign credit_ok = (({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_W);

  // Round-robin search starting at ptr, wrapping modulo NREQ
  always_comb begin
    logic [IDW-1:0] cand;
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    if (rst || !credit_ok) begin
      gnt_found = 1'b0;
      gnt_id    = '0;
    end
  end

  // One-hot grant to the selected requester
  always_comb begin
    req_ready = '0;
    if (gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign push = tag_v[LAT];
  assign pop  = (fifo_count != '0) && rsp_ready;

  // Operand registers and round-robin pointer advance on a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_a <= '0;
      pipe_b <= '0;
      pipe_c <= '0;
      pipe_d <= '0;
      ptr    <= '0;
    end else if (gnt_found) begin
      pipe_a <= a_arr[gnt_id];
      pipe_b <= b_arr[gnt_id];
      pipe_c <= c_arr[gnt_id];
      pipe_d <= d_arr[gnt_id];
      ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Valid/ID tag shift register tracking operations through the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int unsigned i = 0; i <= LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[LAT-1:0], gnt_found};
      tag_id[0] <= gnt_id;
      for (int unsigned i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  // Result FIFO: capture aligned pipe_f, pop on response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_id[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_id[wr_ptr]   <= tag_id[LAT];
        mem_data[wr_ptr] <= pipe_f;
        wr_ptr           <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Count of operations issued but not yet captured
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      unique case ({gnt_found, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = mem_id[rd_ptr];
  assign rsp_data  = mem_data[rd_ptr];
  assign busy      = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: 3-stage datapath model plus a transaction-level
// scoreboard of grants, credits and in-order responses.
module tb_pipe_sched;

  localparam int unsigned N     = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic [N-1:0]      pipe_a, pipe_b, pipe_c, pipe_d;
  logic [N-1:0]      pipe_f = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_data;
  logic              busy;

  pipe_sched #(.N(N), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
    .pipe_f(pipe_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Three-stage arithmetic datapath: F = ((A+B)+(C-D))*D
  logic [N-1:0] s1 = '0, t1 = '0, d1 = '0, s2 = '0, d2 = '0;
  always @(posedge clk) begin
    s1     <= pipe_a + pipe_b;
    t1     <= pipe_c - pipe_d;
    d1     <= pipe_d;
    s2     <= s1 + t1;
    d2     <= d1;
    pipe_f <= s2 * d2;
  end

  typedef struct {
    int           id;
    logic [N-1:0] val;
    int           rdy;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           m_ptr = 0;
  int           outstanding = 0;
  logic [N-1:0] op_a[NREQ], op_b[NREQ], op_c[NREQ], op_d[NREQ];
  logic [N-1:0] exp_pa = '0, exp_pb = '0, exp_pc = '0, exp_pd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = N'($urandom);
      op_b[i] = N'($urandom);
      op_c[i] = N'($urandom);
      op_d[i] = N'($urandom);
    end
  endtask

  function automatic logic [N-1:0] ref_f(input logic [N-1:0] a, b, c, d);
    logic [N-1:0] sum;
    sum = a + b + c - d;
    return N'(sum * d);
  endfunction

  // One clock cycle: drive, compare against the scoreboard, advance it
  task automatic do_cycle(input logic [NREQ-1:0] v, input logic rr);
    int gid;
    logic [NREQ-1:0] exp_rdy;
    logic exp_valid;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = op_a[i];
      req_b[i*N +: N] = op_b[i];
      req_c[i*N +: N] = op_c[i];
      req_d[i*N +: N] = op_d[i];
    end
    #1;
    gid = -1;
    if (outstanding < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gid < 0 && v[(m_ptr + k) % NREQ]) gid = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (gid >= 0) exp_rdy[gid] = 1'b1;
    exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_data", 32'(rsp_data), 32'(q[0].val));
    end
    chk("busy", 32'(busy), 32'(outstanding != 0));
    chk("pipe_a", 32'(pipe_a), 32'(exp_pa));
    chk("pipe_d", 32'(pipe_d), 32'(exp_pd));
    if (exp_valid && rr) begin
      void'(q.pop_front());
      outstanding--;
    end
    if (gid >= 0) begin
      q.push_back('{gid, ref_f(op_a[gid], op_b[gid], op_c[gid], op_d[gid]), cyc + 2 + LAT});
      outstanding++;
      m_ptr  = (gid + 1) % NREQ;
      exp_pa = op_a[gid];
      exp_pb = op_b[gid];
      exp_pc = op_c[gid];
      exp_pd = op_d[gid];
    end
    cyc++;
  endtask

  // Hold reset for n edges, check reset values, then release
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_pipe_a", 32'(pipe_a), 32'h0);
    chk("rst_pipe_b", 32'(pipe_b), 32'h0);
    chk("rst_pipe_c", 32'(pipe_c), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    q.delete();
    m_ptr = 0;
    outstanding = 0;
    exp_pa = '0; exp_pb = '0; exp_pc = '0; exp_pd = '0;
    cyc += n + 1;
  endtask

  initial begin
    rand_ops();
    do_reset(2);

    // Single request from requester 2: (1+2+10-3)*3 = 30
    op_a[2] = 8'd1; op_b[2] = 8'd2; op_c[2] = 8'd10; op_d[2] = 8'd3;
    do_cycle(4'b0100, 1'b1);
    repeat (7) do_cycle(4'b0000, 1'b1);

    // Wrap-around operands: 43, then 84
    op_a[0] = 8'd200; op_b[0] = 8'd100; op_c[0] = 8'd0; op_d[0] = 8'd1;
    op_a[1] = 8'd200; op_b[1] = 8'd100; op_c[1] = 8'd0; op_d[1] = 8'd2;
    do_cycle(4'b0001, 1'b1);
    do_cycle(4'b0010, 1'b1);
    repeat (7) do_cycle(4'b0000, 1'b1);

    // All requesters active, consumer always ready
    for (int i = 0; i < 24; i++) begin
      rand_ops();
      do_cycle(4'b1111, 1'b1);
    end
    repeat (8) do_cycle(4'b0000, 1'b1);

    // Consumer stalled: credit caps issue at DEPTH, then drain and resume
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      do_cycle(4'b1111, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      do_cycle(4'b1111, 1'b1);
    end
    repeat (10) do_cycle(4'b0000, 1'b1);

    // Single requester streaming: push and pop together at count 1
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      do_cycle(4'b1000, 1'b1);
    end
    repeat (8) do_cycle(4'b0000, 1'b1);

    // Random requests and back-pressure
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      do_cycle(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    repeat (20) do_cycle(4'b0000, 1'b1);

    // Reset two cycles after three grants: those results never appear
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      do_cycle(4'b1111, 1'b1);
    end
    do_cycle(4'b0000, 1'b1);
    do_reset(1);
    repeat (12) do_cycle(4'b0000, 1'b1);

    // Normal operation after mid-flight reset
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      do_cycle(4'b0101, 1'b1);
    end
    repeat (10) do_cycle(4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
